dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Two-port (CPU + secondary DMA/debug) data-memory arbiter.
//             Round-robin grant, big-endian byte-lane steering for
//             word/half/byte accesses, load extraction with sign/zero
//             extension, illegal-access detection and ISSUE timeout.
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             c_*                - CPU requester (req/we/addr/wdata/ds/sx in,
//                                  rdata/done/err out)
//             d_*                - secondary requester, same set as c_*
//             m_req/m_we/m_addr/m_be/m_wdata - registered memory request
//             m_ack/m_rdata      - memory completion strobe and load data
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  // CPU port
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [1:0]  c_ds,
  input  logic        c_sx,
  output logic [31:0] c_rdata,
  output logic        c_done,
  output logic        c_err,
  // Secondary port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_ds,
  input  logic        d_sx,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_err,
  // Memory side
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_be,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state_q;
  logic        rr_d_q;      // 1: secondary port wins the next tie
  logic        gnt_d_q;     // 1: current access belongs to the secondary port
  logic [1:0]  off_q;
  logic [1:0]  ds_q;
  logic        sx_q;
  logic [7:0]  cnt_q;
  logic        m_req_q, m_we_q;
  logic [31:0] m_addr_q, m_wdata_q;
  logic [3:0]  m_be_q;
  logic [31:0] c_rdata_q, d_rdata_q;
  logic        c_done_q, d_done_q, c_err_q, d_err_q;

  // Grant selection and field mux for the port being granted this cycle
  logic        pick_d_d;
  logic        sel_we_d, sel_sx_d, illegal_d;
  logic [31:0] sel_addr_d, sel_wdata_d;
  logic [1:0]  sel_ds_d;
  logic [3:0]  be_d;
  logic [31:0] wd_d;
  logic [31:0] ld_data_d;

  assign pick_d_d    = d_req && (!c_req || rr_d_q);
  assign sel_we_d    = pick_d_d ? d_we    : c_we;
  assign sel_sx_d    = pick_d_d ? d_sx    : c_sx;
  assign sel_addr_d  = pick_d_d ? d_addr  : c_addr;
  assign sel_wdata_d = pick_d_d ? d_wdata : c_wdata;
  assign sel_ds_d    = pick_d_d ? d_ds    : c_ds;
  // Half accesses must be 2-byte aligned; ds=11 is never legal
  assign illegal_d   = (sel_ds_d == 2'b11) || ((sel_ds_d == 2'b01) && sel_addr_d[0]);

  // Big-endian lane steering: byte offset k lives in bits [31-8k:24-8k]
  always_comb begin
    be_d = 4'b0000;
    wd_d = 32'h0;
    case (sel_ds_d)
      2'b00: begin
        be_d = 4'b1111;
        wd_d = sel_wdata_d;
      end
      2'b01: begin
        if (sel_addr_d[1]) begin
          be_d = 4'b1100;
          wd_d = {16'h0, sel_wdata_d[15:0]};
        end else begin
          be_d = 4'b0011;
          wd_d = {sel_wdata_d[15:0], 16'h0};
        end
      end
      2'b10: begin
        case (sel_addr_d[1:0])
          2'd0:    begin be_d = 4'b0001; wd_d = {sel_wdata_d[7:0], 24'h0}; end
          2'd1:    begin be_d = 4'b0010; wd_d = {8'h0, sel_wdata_d[7:0], 16'h0}; end
          2'd2:    begin be_d = 4'b0100; wd_d = {16'h0, sel_wdata_d[7:0], 8'h0}; end
          default: begin be_d = 4'b1000; wd_d = {24'h0, sel_wdata_d[7:0]}; end
        endcase
      end
      default: begin
        be_d = 4'b0000;
        wd_d = 32'h0;
      end
    endcase
  end

  // Load extraction from the lanes of the access in flight
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'h0;
    case (off_q)
      2'd0:    b = m_rdata[31:24];
      2'd1:    b = m_rdata[23:16];
      2'd2:    b = m_rdata[15:8];
      default: b = m_rdata[7:0];
    endcase
    h = off_q[1] ? m_rdata[15:0] : m_rdata[31:16];
    case (ds_q)
      2'b00:   ld_data_d = m_rdata;
      2'b01:   ld_data_d = {{16{sx_q & h[15]}}, h};
      default: ld_data_d = {{24{sx_q & b[7]}}, b};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rr_d_q    <= 1'b0;
      gnt_d_q   <= 1'b0;
      off_q     <= 2'b00;
      ds_q      <= 2'b00;
      sx_q      <= 1'b0;
      cnt_q     <= 8'd0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= 32'h0;
      m_be_q    <= 4'b0000;
      m_wdata_q <= 32'h0;
      c_rdata_q <= 32'h0;
      d_rdata_q <= 32'h0;
      c_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      c_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (c_req || d_req) begin
            gnt_d_q <= pick_d_d;
            rr_d_q  <= !pick_d_d;
            off_q   <= sel_addr_d[1:0];
            ds_q    <= sel_ds_d;
            sx_q    <= sel_sx_d;
            if (illegal_d) begin
              // Rejected without a memory cycle
              state_q <= S_DONE;
              if (pick_d_d) begin
                d_done_q  <= 1'b1;
                d_err_q   <= 1'b1;
                d_rdata_q <= 32'h0;
              end else begin
                c_done_q  <= 1'b1;
                c_err_q   <= 1'b1;
                c_rdata_q <= 32'h0;
              end
            end else begin
              state_q   <= S_ISSUE;
              cnt_q     <= 8'd0;
              m_req_q   <= 1'b1;
              m_we_q    <= sel_we_d;
              m_addr_q  <= {sel_addr_d[31:2], 2'b00};
              m_be_q    <= be_d;
              m_wdata_q <= sel_we_d ? wd_d : 32'h0;
            end
          end
        end

        S_ISSUE: begin
          // An ack in the final timeout cycle still completes normally
          if (m_ack || (cnt_q == TO_LAST)) begin
            state_q <= S_DONE;
            m_req_q <= 1'b0;
            if (gnt_d_q) begin
              d_done_q  <= 1'b1;
              d_err_q   <= !m_ack;
              d_rdata_q <= (m_ack && !m_we_q) ? ld_data_d : 32'h0;
            end else begin
              c_done_q  <= 1'b1;
              c_err_q   <= !m_ack;
              c_rdata_q <= (m_ack && !m_we_q) ? ld_data_d : 32'h0;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        default: begin
          // DONE: single-cycle pulse, requests not sampled here
          state_q  <= S_IDLE;
          c_done_q <= 1'b0;
          d_done_q <= 1'b0;
          c_err_q  <= 1'b0;
          d_err_q  <= 1'b0;
        end
      endcase
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_be    = m_be_q;
  assign m_wdata = m_wdata_q;
  assign c_rdata = c_rdata_q;
  assign c_done  = c_done_q;
  assign c_err   = c_err_q;
  assign d_rdata = d_rdata_q;
  assign d_done  = d_done_q;
  assign d_err   = d_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Directed self-checking bench for dmem_arbiter (TIMEOUT=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, c_sx, d_req, d_we, d_sx;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic [1:0]  c_ds, d_ds;
  logic [31:0] c_rdata, d_rdata;
  logic        c_done, c_err, d_done, d_err;
  logic        m_req, m_we, m_ack;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.TIMEOUT(4)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .c_req   (c_req),
    .c_we    (c_we),
    .c_addr  (c_addr),
    .c_wdata (c_wdata),
    .c_ds    (c_ds),
    .c_sx    (c_sx),
    .c_rdata (c_rdata),
    .c_done  (c_done),
    .c_err   (c_err),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_ds    (d_ds),
    .d_sx    (d_sx),
    .d_rdata (d_rdata),
    .d_done  (d_done),
    .d_err   (d_err),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_be    (m_be),
    .m_wdata (m_wdata),
    .m_ack   (m_ack),
    .m_rdata (m_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called in the first ISSUE cycle; ack is raised in ISSUE cycle n,
  // returns in the DONE cycle.
  task automatic ack_after(input int n);
    for (int i = 1; i < n; i++) tick();
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0; c_ds = 0; c_sx = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_ds = 0; d_sx = 0;
    m_ack = 0; m_rdata = 0;
    repeat (2) tick();
    chk("rst_m_req",   m_req,   0);
    chk("rst_m_be",    m_be,    0);
    chk("rst_m_addr",  m_addr,  0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_c_done",  c_done,  0);
    chk("rst_d_done",  d_done,  0);
    chk("rst_c_rdata", c_rdata, 0);
    rst = 1'b0;

    // Stray ack while idle does nothing
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
    chk("idle_ack_m_req",  m_req,  0);
    chk("idle_ack_c_done", c_done, 0);
    chk("idle_ack_d_done", d_done, 0);

    // CPU byte store at 0x103, ack in 3rd ISSUE cycle
    c_we = 1; c_addr = 32'h103; c_wdata = 32'hAABBCCDD; c_ds = 2'b10; c_req = 1;
    tick();
    chk("bst_m_req",   m_req,   1);
    chk("bst_m_we",    m_we,    1);
    chk("bst_m_addr",  m_addr,  32'h100);
    chk("bst_m_be",    m_be,    4'b1000);
    chk("bst_m_wdata", m_wdata, 32'h000000DD);
    ack_after(3);
    chk("bst_c_done", c_done, 1);
    chk("bst_c_err",  c_err,  0);
    chk("bst_d_done", d_done, 0);
    chk("bst_m_req_drop", m_req, 0);
    c_req = 0;
    tick();
    chk("bst_done_pulse", c_done, 0);

    // CPU half load at 0x202, sign-extended then zero-extended
    c_we = 0; c_addr = 32'h202; c_wdata = 32'hFFFFFFFF; c_ds = 2'b01; c_sx = 1; c_req = 1;
    tick();
    chk("hld_m_we",    m_we,    0);
    chk("hld_m_be",    m_be,    4'b1100);
    chk("hld_m_wdata", m_wdata, 0);
    chk("hld_m_addr",  m_addr,  32'h200);
    m_rdata = 32'h1234F00D;
    ack_after(1);
    chk("hld_sx1", c_rdata, 32'hFFFFF00D);
    c_req = 0;
    tick();
    chk("hld_hold", c_rdata, 32'hFFFFF00D);
    c_sx = 0; c_req = 1;
    tick();
    ack_after(2);
    chk("hld_sx0", c_rdata, 32'h0000F00D);
    c_req = 0;
    tick();

    // CPU byte load at offset 1, sign-extended
    c_addr = 32'h401; c_ds = 2'b10; c_sx = 1; m_rdata = 32'h12F45678; c_req = 1;
    tick();
    chk("bld_m_be", m_be, 4'b0010);
    ack_after(1);
    chk("bld_rdata", c_rdata, 32'hFFFFFFF4);
    c_req = 0;
    tick();

    // Secondary word store
    d_we = 1; d_addr = 32'h50C; d_wdata = 32'hCAFEBABE; d_ds = 2'b00; d_req = 1;
    tick();
    chk("wst_m_be",    m_be,    4'b1111);
    chk("wst_m_wdata", m_wdata, 32'hCAFEBABE);
    chk("wst_m_addr",  m_addr,  32'h50C);
    ack_after(1);
    chk("wst_d_done",  d_done,  1);
    chk("wst_c_done",  c_done,  0);
    chk("wst_d_rdata", d_rdata, 0);
    d_req = 0;
    tick();

    // Timeout: m_req high exactly 4 cycles, then error
    c_we = 0; c_addr = 32'h300; c_ds = 2'b00; c_sx = 0; c_req = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("to_m_req_high", m_req, 1);
      tick();
    end
    chk("to_m_req_low", m_req,   0);
    chk("to_c_done",    c_done,  1);
    chk("to_c_err",     c_err,   1);
    chk("to_c_rdata",   c_rdata, 0);
    c_req = 0;
    tick();
    chk("to_err_clear", c_err, 0);

    // Ack on the 4th (last) ISSUE cycle wins over the timeout
    m_rdata = 32'h89ABCDEF; c_req = 1;
    tick();
    ack_after(4);
    chk("ack4_c_done",  c_done,  1);
    chk("ack4_c_err",   c_err,   0);
    chk("ack4_c_rdata", c_rdata, 32'h89ABCDEF);
    c_req = 0;
    tick();

    // Illegal: half store at odd offset, then ds=11
    c_we = 1; c_addr = 32'h101; c_ds = 2'b01; c_req = 1;
    tick();
    chk("ill_h_m_req",  m_req,  0);
    chk("ill_h_c_done", c_done, 1);
    chk("ill_h_c_err",  c_err,  1);
    c_req = 0;
    tick();
    d_we = 0; d_addr = 32'h600; d_ds = 2'b11; d_req = 1;
    tick();
    chk("ill_ds_m_req",   m_req,   0);
    chk("ill_ds_d_done",  d_done,  1);
    chk("ill_ds_d_err",   d_err,   1);
    chk("ill_ds_d_rdata", d_rdata, 0);
    d_req = 0;
    tick();

    // Reset in the 2nd ISSUE cycle of a CPU access (leaves pointer on D)
    c_we = 1; c_addr = 32'h1000; c_wdata = 32'h11111111; c_ds = 2'b00; c_req = 1;
    tick();
    tick();
    rst = 1'b1; c_req = 0;
    tick();
    chk("mrst_m_req",  m_req,  0);
    chk("mrst_c_done", c_done, 0);
    rst = 1'b0;
    tick();
    chk("mrst_c_done2", c_done, 0);

    // Both held: grants C, D, C, D starting with CPU after reset
    d_we = 1; d_addr = 32'h2000; d_wdata = 32'h22222222; d_ds = 2'b00;
    c_req = 1; d_req = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_m_addr", m_addr, (k % 2 == 0) ? 32'h1000 : 32'h2000);
      ack_after(1);
      chk("rr_c_done", c_done, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_d_done", d_done, (k % 2 == 0) ? 32'd0 : 32'd1);
      tick();
    end
    c_req = 0; d_req = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
